// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the multi-channel pulse transmitter: register map,
// CTRL/TIMING field offsets, channel state encoding and sizing helpers.
package pulse_tx_pkg;

    localparam logic [7:0] CTRL_BASE       = 8'h00;
    localparam logic [7:0] SYNC_START_ADDR = 8'h3E;
    localparam logic [7:0] IRQ_CLR_ADDR    = 8'h3F;
    localparam logic [7:0] DUR_BASE        = 8'h40;
    localparam logic [7:0] MEM_BASE        = 8'h80;

    localparam int CTRL_START    = 0;
    localparam int CTRL_IDLE     = 1;
    localparam int CTRL_INVERT   = 2;
    localparam int CTRL_CARRIER  = 3;
    localparam int CTRL_LB_LSB   = 4;
    localparam int CTRL_END_LSB  = 12;
    localparam int CTRL_LOOP_LSB = 20;
    localparam int CTRL_IRQ_EN   = 28;

    localparam int TIM_HALF_LSB  = 0;
    localparam int TIM_PRE_LSB   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2
    } ch_state_e;

    // Number of symbols held in the shared symbol memory.
    function automatic int pulse_tx_num_sym(input int mem_words, input int symbol_bits);
        return mem_words * 32 / symbol_bits;
    endfunction

    // Width of a symbol index (at least 1 bit).
    function automatic int pulse_tx_idx_w(input int num_sym);
        return (num_sym <= 2) ? 1 : $clog2(num_sym);
    endfunction

endpackage

// File: rtl/pulse_tx_channel.sv
// One symbol sequencer: FSM, program counter, loop counter, prescaled
// symbol timer and carrier generator. Symbol data is supplied by the top
// level through a combinational read of the shared memory at rd_idx_o.
module pulse_tx_channel
    import pulse_tx_pkg::*;
#(
    parameter int IDX_W       = 7,
    parameter int DURATION_W  = 8,
    parameter int PRESCALER_W = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [7:0]             loopback_i,
    input  logic [7:0]             end_i,
    input  logic [7:0]             loop_count_i,
    input  logic [PRESCALER_W-1:0] prescaler_i,
    input  logic [15:0]            carrier_half_i,
    input  logic                   carrier_en_i,
    input  logic                   idle_level_i,
    input  logic                   invert_i,
    input  logic                   sym_level_i,
    input  logic [DURATION_W-1:0]  sym_dur_i,
    output logic [IDX_W-1:0]       rd_idx_o,
    output logic                   ch_out_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fin_o
);

    // Longest symbol is 2^DURATION_W << (2^PRESCALER_W - 1) cycles.
    localparam int TIMER_W = DURATION_W + (1 << PRESCALER_W);

    ch_state_e              state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d, lb_q, lb_d, next_idx;
    logic [7:0]             end_q, end_d, loops_q, loops_d;
    logic [PRESCALER_W-1:0] pre_q, pre_d;
    logic [TIMER_W-1:0]     timer_q, timer_d, sym_len_m1;
    logic                   level_q, level_d, car_q, car_d, done_q, done_d;
    logic [15:0]            car_cnt_q, car_cnt_d;
    logic                   at_end, last_sym, boundary;

    // End comparison is 9 bits wide so an end index beyond the memory never matches.
    assign at_end     = (9'(idx_q) == 9'(end_q));
    assign last_sym   = at_end && (loops_q == 8'd0);
    assign next_idx   = (at_end && (loops_q != 8'd0)) ? lb_q : idx_q + IDX_W'(1);
    assign sym_len_m1 = ((TIMER_W'(sym_dur_i) + TIMER_W'(1)) << pre_q) - TIMER_W'(1);
    assign boundary   = (state_q == RUN) && (timer_q == '0);
    assign rd_idx_o   = (state_q == FETCH) ? '0 : next_idx;
    assign fin_o      = boundary && last_sym && !abort_i && !start_i;

    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
    assign ch_out_o = (busy_o ? (carrier_en_i ? (level_q & car_q) : level_q) : idle_level_i) ^ invert_i;

    // Next-state logic: abort beats start, start beats normal sequencing.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lb_d      = lb_q;
        end_d     = end_q;
        loops_d   = loops_q;
        pre_d     = pre_q;
        timer_d   = timer_q;
        level_d   = level_q;
        done_d    = 1'b0;
        car_d     = 1'b0;
        car_cnt_d = '0;
        if (abort_i) begin
            state_d = IDLE;
        end else if (start_i) begin
            state_d = FETCH;
            idx_d   = '0;
            lb_d    = IDX_W'(loopback_i);
            end_d   = end_i;
            loops_d = loop_count_i;
            pre_d   = prescaler_i;
        end else begin
            case (state_q)
                FETCH: begin
                    state_d = RUN;
                    level_d = sym_level_i;
                    timer_d = sym_len_m1;
                end
                RUN: begin
                    if (timer_q == '0) begin
                        if (last_sym) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            if (at_end) begin
                                loops_d = loops_q - 8'd1;
                            end
                            idx_d   = next_idx;
                            level_d = sym_level_i;
                            timer_d = sym_len_m1;
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        // Carrier starts high on the first busy cycle and is parked low otherwise.
        if (state_d == RUN) begin
            if (state_q != RUN) begin
                car_d = 1'b1;
            end else if (car_cnt_q == carrier_half_i) begin
                car_d = ~car_q;
            end else begin
                car_d     = car_q;
                car_cnt_d = car_cnt_q + 16'd1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            lb_q      <= '0;
            end_q     <= '0;
            loops_q   <= '0;
            pre_q     <= '0;
            timer_q   <= '0;
            level_q   <= 1'b0;
            car_q     <= 1'b0;
            car_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lb_q      <= lb_d;
            end_q     <= end_d;
            loops_q   <= loops_d;
            pre_q     <= pre_d;
            timer_q   <= timer_d;
            level_q   <= level_d;
            car_q     <= car_d;
            car_cnt_q <= car_cnt_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: rtl/pulse_transmitter_mc.sv
// Multi-channel pulse transmitter top: register file, shared symbol memory,
// duration table, per-channel symbol mux and sticky interrupt flags.
// Optional macro PULSE_TX_SYNC_START_EN adds the SYNC_START register at 0x3E.
module pulse_transmitter_mc
    import pulse_tx_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int MEM_WORDS   = 8,
    parameter int SYMBOL_BITS = 2,
    parameter int DURATION_W  = 8,
    parameter int PRESCALER_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [31:0]       wr_data,
    output logic [NUM_CH-1:0] ch_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic              irq
);

    localparam int NUM_SYM = pulse_tx_num_sym(MEM_WORDS, SYMBOL_BITS);
    localparam int IDX_W   = pulse_tx_idx_w(NUM_SYM);
    localparam int NUM_DUR = 1 << SYMBOL_BITS;
    localparam int TIM_W   = TIM_PRE_LSB + PRESCALER_W;

    logic [28:0]            ctrl_q   [NUM_CH];
    logic [TIM_W-1:0]       timing_q [NUM_CH];
    logic [DURATION_W-1:0]  dur_q    [NUM_DUR];
    logic [MEM_WORDS*32-1:0] mem_q;
    logic [NUM_CH-1:0]      flag_q, fin, irq_en, irq_clr, sync_start;

    // Register file writes; symbols are packed LSB-first, so symbol i sits at bit i*SYMBOL_BITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                ctrl_q[c]   <= '0;
                timing_q[c] <= '0;
            end
            for (int k = 0; k < NUM_DUR; k++) begin
                dur_q[k] <= '0;
            end
            mem_q <= '0;
        end else if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_addr == CTRL_BASE + 8'(2 * c))     ctrl_q[c]   <= wr_data[28:0];
                if (wr_addr == CTRL_BASE + 8'(2 * c + 1)) timing_q[c] <= wr_data[TIM_W-1:0];
            end
            for (int k = 0; k < NUM_DUR; k++) begin
                if (wr_addr == DUR_BASE + 8'(k)) dur_q[k] <= wr_data[DURATION_W-1:0];
            end
            for (int w = 0; w < MEM_WORDS; w++) begin
                if (wr_addr == MEM_BASE + 8'(w)) mem_q[w*32 +: 32] <= wr_data;
            end
        end
    end

    assign irq_clr = (wr_en && (wr_addr == IRQ_CLR_ADDR)) ? wr_data[NUM_CH-1:0] : '0;

`ifdef PULSE_TX_SYNC_START_EN
    assign sync_start = (wr_en && (wr_addr == SYNC_START_ADDR)) ? wr_data[NUM_CH-1:0] : '0;
`else
    assign sync_start = '0;
`endif

    // Sticky completion flags: a set in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q <= '0;
        end else begin
            flag_q <= (flag_q & ~irq_clr) | (fin & irq_en);
        end
    end

    assign irq = |flag_q;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic                   ctrl_hit, start_edge, abort;
            logic [28:0]            ctrl_src;
            logic [IDX_W-1:0]       rd_idx;
            logic [SYMBOL_BITS-1:0] sym;

            assign ctrl_hit   = wr_en && (wr_addr == CTRL_BASE + 8'(2 * gi));
            // Sequence fields come from the write itself when CTRL is written this cycle.
            assign ctrl_src   = ctrl_hit ? wr_data[28:0] : ctrl_q[gi];
            assign start_edge = (ctrl_hit && wr_data[CTRL_START] && !ctrl_q[gi][CTRL_START]) || sync_start[gi];
            assign abort      = ctrl_hit && !wr_data[CTRL_START];
            assign sym        = mem_q[int'(rd_idx) * SYMBOL_BITS +: SYMBOL_BITS];
            assign irq_en[gi] = ctrl_q[gi][CTRL_IRQ_EN];

            pulse_tx_channel #(
                .IDX_W       (IDX_W),
                .DURATION_W  (DURATION_W),
                .PRESCALER_W (PRESCALER_W)
            ) u_ch (
                .clk_i          (clk),
                .rst_ni         (rst_n),
                .start_i        (start_edge),
                .abort_i        (abort),
                .loopback_i     (ctrl_src[CTRL_LB_LSB +: 8]),
                .end_i          (ctrl_src[CTRL_END_LSB +: 8]),
                .loop_count_i   (ctrl_src[CTRL_LOOP_LSB +: 8]),
                .prescaler_i    (timing_q[gi][TIM_PRE_LSB +: PRESCALER_W]),
                .carrier_half_i (timing_q[gi][TIM_HALF_LSB +: 16]),
                .carrier_en_i   (ctrl_q[gi][CTRL_CARRIER]),
                .idle_level_i   (ctrl_q[gi][CTRL_IDLE]),
                .invert_i       (ctrl_q[gi][CTRL_INVERT]),
                .sym_level_i    (sym[SYMBOL_BITS-1]),
                .sym_dur_i      (dur_q[sym]),
                .rd_idx_o       (rd_idx),
                .ch_out_o       (ch_out[gi]),
                .busy_o         (busy[gi]),
                .done_o         (done[gi]),
                .fin_o          (fin[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pulse_transmitter_mc.sv
// Self-checking bench for pulse_transmitter_mc (default parameters).
module tb_pulse_transmitter_mc;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0] ch_out, busy, done;
    logic       irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_transmitter_mc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .ch_out  (ch_out),
        .busy    (busy),
        .done    (done),
        .irq     (irq)
    );

    typedef struct packed {
        logic out;
        logic bsy;
        logic dn;
    } samp_t;

    typedef struct {
        string           name;
        int              ch;
        logic [31:0]     mem0;
        logic [31:0]     mem7;
        logic [3:0][7:0] dur;
        logic [31:0]     ctrl;
        logic [31:0]     timing;
    } vec_t;

    samp_t exp_q[$];
    vec_t  vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    function automatic logic [31:0] mk_ctrl(input logic st, input logic idl, input logic inv,
                                            input logic car, input logic [7:0] lb,
                                            input logic [7:0] en, input logic [7:0] lp,
                                            input logic ie);
        return {3'b000, ie, lp, en, lb, car, inv, idl, st};
    endfunction

    function automatic int sym_at(input vec_t v, input int idx);
        logic [31:0] w;
        w = (idx / 16 == 0) ? v.mem0 : ((idx / 16 == 7) ? v.mem7 : 32'h0);
        return int'((w >> ((idx % 16) * 2)) & 32'h3);
    endfunction

    // Reference waveform: one sample per cycle starting with the fetch cycle.
    task automatic build_expect(input vec_t v);
        int idx, loops, pre, half, endi, lb, t, sym, len, guard;
        logic idl, inv, car_en, lvl, car;
        samp_t s;
        idx = 0; t = 0; guard = 0;
        loops  = int'(v.ctrl[27:20]);
        endi   = int'(v.ctrl[19:12]);
        lb     = int'(v.ctrl[11:4]);
        car_en = v.ctrl[3]; inv = v.ctrl[2]; idl = v.ctrl[1];
        pre    = int'(v.timing[19:16]);
        half   = int'(v.timing[15:0]);
        s = '{out: idl ^ inv, bsy: 1'b0, dn: 1'b0};
        exp_q.push_back(s);
        while (guard < 200) begin
            guard++;
            sym = sym_at(v, idx);
            len = (int'(v.dur[sym]) + 1) << pre;
            lvl = sym[1];
            for (int c = 0; c < len; c++) begin
                car = ((t / (half + 1)) % 2) == 0;
                s = '{out: (car_en ? (lvl & car) : lvl) ^ inv, bsy: 1'b1, dn: 1'b0};
                exp_q.push_back(s);
                t++;
            end
            if (idx == endi) begin
                if (loops > 0) begin
                    idx = lb; loops--;
                end else begin
                    break;
                end
            end else begin
                idx = (idx + 1) % 128;
            end
        end
        s = '{out: idl ^ inv, bsy: 1'b0, dn: 1'b1};
        exp_q.push_back(s);
        s = '{out: idl ^ inv, bsy: 1'b0, dn: 1'b0};
        exp_q.push_back(s);
    endtask

    task automatic run_vec(input vec_t v);
        samp_t e;
        int n;
        wr(8'(2 * v.ch + 1), v.timing);
        for (int k = 0; k < 4; k++) wr(8'(8'h40 + k), 32'(v.dur[k]));
        for (int w = 0; w < 8; w++) wr(8'(8'h80 + w), (w == 0) ? v.mem0 : ((w == 7) ? v.mem7 : 32'h0));
        build_expect(v);
        n = exp_q.size();
        wr(8'(2 * v.ch), v.ctrl);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({v.name, " out/busy/done"}, 32'({ch_out[v.ch], busy[v.ch], done[v.ch]}), 32'(e));
            if (exp_q.size() > 0) @(negedge clk);
        end
        wr(8'(2 * v.ch), v.ctrl & ~32'h1);
        $display("vector %s ch%0d: %0d cycles compared", v.name, v.ch, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c0, c1;
        int dn_cnt;
        bit found;

        vecs[0] = '{"basic",      0, 32'hE4, 32'h0, {8'd0, 8'd1, 8'd7, 8'd3}, mk_ctrl(1,0,0,0,8'd0,  8'd3,8'd0,0), 32'h0};
        vecs[1] = '{"loop",       0, 32'hE4, 32'h0, {8'd0, 8'd1, 8'd7, 8'd3}, mk_ctrl(1,0,0,0,8'd2,  8'd3,8'd2,0), 32'h0};
        vecs[2] = '{"presc_car",  0, 32'h02, 32'h0, {8'd0, 8'd1, 8'd0, 8'd0}, mk_ctrl(1,0,0,1,8'd0,  8'd0,8'd0,0), 32'h0002_0000};
        vecs[3] = '{"idle_high",  0, 32'hE4, 32'h0, {8'd0, 8'd1, 8'd7, 8'd3}, mk_ctrl(1,1,0,0,8'd0,  8'd1,8'd0,0), 32'h0};
        vecs[4] = '{"ch1_inv_car",1, 32'hE4, 32'h0, {8'd0, 8'd1, 8'd7, 8'd3}, mk_ctrl(1,0,1,1,8'd0,  8'd3,8'd0,0), 32'h0000_0001};
        vecs[5] = '{"wrap",       0, 32'hE4, 32'hC000_0000, {8'd0, 8'd1, 8'd7, 8'd3}, mk_ctrl(1,0,0,0,8'd127,8'd1,8'd1,0), 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset ch_out", 32'(ch_out), 32'h0);
        check("reset busy",   32'(busy),   32'h0);
        check("reset done",   32'(done),   32'h0);
        check("reset irq",    32'(irq),    32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post-reset ch_out", 32'(ch_out), 32'h0);
        $display("reset state sampled");

        foreach (vecs[i]) run_vec(vecs[i]);

        // Abort mid-run with irq_en set: no done, no flag
        wr(8'h01, 32'h0);
        wr(8'h40, 32'd3); wr(8'h41, 32'd7); wr(8'h42, 32'd1); wr(8'h43, 32'd0);
        wr(8'h80, 32'hE4); wr(8'h87, 32'h0);
        c0 = mk_ctrl(1,0,0,0,8'd0,8'd3,8'd0,1);
        wr(8'h00, c0);
        repeat (4) @(negedge clk);
        check("abort pre busy", 32'(busy[0]), 32'h1);
        wr(8'h00, c0 & ~32'h1);
        check("abort busy",   32'(busy[0]),   32'h0);
        check("abort ch_out", 32'(ch_out[0]), 32'h0);
        dn_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done[0]) dn_cnt++;
        end
        check("abort done count", 32'(dn_cnt), 32'h0);
        check("abort irq", 32'(irq), 32'h0);
        $display("abort sequence ch0 done");

        // Rerun to completion: flag set
        wr(8'h00, c0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (done[0]) found = 1;
        end
        check("rerun done seen", 32'(found), 32'h1);
        check("rerun irq", 32'(irq), 32'h1);
        wr(8'h00, c0 & ~32'h1);
        wr(8'h3F, 32'h1);
        check("irq cleared", 32'(irq), 32'h0);
        $display("rerun ch0 complete, irq set then cleared");

        // IRQ_CLR in the same cycle as ch1 completion: set wins
        wr(8'h03, 32'h0);
        c1 = mk_ctrl(1,0,0,0,8'd0,8'd3,8'd0,1);
        wr(8'h02, c1);
        repeat (14) @(negedge clk);
        check("ch1 busy before end", 32'(busy[1]), 32'h1);
        wr(8'h3F, 32'h2);
        check("ch1 done at clr", 32'(done[1]), 32'h1);
        check("ch1 busy at clr", 32'(busy[1]), 32'h0);
        check("irq set wins",    32'(irq),     32'h1);
        wr(8'h02, c1 & ~32'h1);
        $display("clear coinciding with ch1 completion");

        // Asynchronous reset mid-run on both channels
        wr(8'h00, mk_ctrl(1,0,1,0,8'd0,8'd3,8'd0,0));
        wr(8'h02, mk_ctrl(1,0,0,0,8'd0,8'd3,8'd0,0));
        repeat (2) @(negedge clk);
        check("pre-reset ch_out0", 32'(ch_out[0]), 32'h1);
        check("pre-reset busy",    32'(busy),      32'h3);
        #2 rst_n = 1'b0;
        #1;
        check("async reset ch_out", 32'(ch_out), 32'h0);
        check("async reset busy",   32'(busy),   32'h0);
        check("async reset irq",    32'(irq),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset mid-run");

        wr(8'h40, 32'd3); wr(8'h41, 32'd7); wr(8'h42, 32'd1); wr(8'h43, 32'd0);
        wr(8'h80, 32'hE4);
        wr(8'h00, mk_ctrl(0,1,0,0,8'd0,8'd3,8'd0,0));
        wr(8'h02, mk_ctrl(0,1,0,0,8'd0,8'd3,8'd0,0));
        wr(8'h3E, 32'h3);
`ifdef PULSE_TX_SYNC_START_EN
        check("sync fetch ch_out", 32'(ch_out), 32'h3);
        check("sync fetch busy",   32'(busy),   32'h0);
        @(negedge clk);
        check("sync first edge ch_out", 32'(ch_out), 32'h0);
        check("sync busy",              32'(busy),   32'h3);
        $display("sync start both channels");
`else
        repeat (2) @(negedge clk);
        check("0x3E ignored busy",   32'(busy),   32'h0);
        check("0x3E ignored ch_out", 32'(ch_out), 32'h3);
        $display("sync start address ignored");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
